apb4_mem_slave: RTL

Parametrised APB4 memory-mapped slave, successor to the team's basic APB memory slave.
- Adds configurable depth and data width, byte-lane write strobes (pstrb), programmable wait states and pslverr for out-of-range accesses.
- Sits behind the APB bridge/decoder as a generic scratchpad or register-file target for subsystem bring-up and verification.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_mem_array.sv | 34 +++
 rtl/apb4_mem_slave.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state type, response codes and
// width helpers used to derive strobe/index widths from bus parameters.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_st_e;

    localparam logic OKAY   = 1'b0;
    localparam logic SLVERR = 1'b1;

    function automatic int unsigned strb_width(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned off_width(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int unsigned idx_width(input int unsigned aw, input int unsigned dw);
        return aw - off_width(dw);
    endfunction

    function automatic int unsigned mem_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH storage with a byte-enabled synchronous write port
// and an asynchronous read port. Contents are intentionally not reset.
module apb_mem_array
    import apb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 256,
    localparam int unsigned STRB_W     = strb_width(DATA_WIDTH),
    localparam int unsigned MEM_AW     = mem_addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [MEM_AW-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    input  logic [MEM_AW-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 scratchpad slave: programmable wait states, byte strobes and
// pslverr for word indices beyond DEPTH. Outputs are registered.
module apb4_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
    localparam int unsigned OFF_W  = off_width(DATA_WIDTH);
    localparam int unsigned IDX_W  = idx_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned MEM_AW = mem_addr_width(DEPTH);
    localparam logic [IDX_W:0] DEPTH_L  = (IDX_W+1)'(DEPTH);
    localparam logic [3:0]     CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    apb_slv_st_e             state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic                    pready_q, pready_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    cur_wr;
    logic [IDX_W-1:0]        idx;
    logic                    in_range;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_we;
    logic                    enter_ready;

    // With no wait states READY is entered straight from IDLE, so the range
    // check and read port must see the live bus rather than the latch.
    assign cur_addr = (state_q == IDLE) ? paddr  : addr_q;
    assign cur_wr   = (state_q == IDLE) ? pwrite : wr_q;
    assign idx      = IDX_W'(cur_addr >> OFF_W);
    assign in_range = ({1'b0, idx} < DEPTH_L);

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (idx[MEM_AW-1:0]),
        .wdata_i (wdata_q),
        .wstrb_i (strb_q),
        .raddr_i (idx[MEM_AW-1:0]),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        enter_ready = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    if (WAIT_CYCLES == 0) begin
                        enter_ready = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q == '0) begin
                        enter_ready = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            READY: begin
                state_d = IDLE;
                mem_we  = psel && wr_q && in_range;
            end
            default: state_d = IDLE;
        endcase

        if (enter_ready) begin
            state_d = READY;
        end

        pready_d  = enter_ready;
        pslverr_d = (enter_ready && !in_range) ? SLVERR : OKAY;
        prdata_d  = (enter_ready && !cur_wr && in_range) ? mem_rdata : '0;
    end

    assign pready  = pready_q;
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;

endmodule
